// File: rtl/dcm_lock_supervisor.sv
// Per-channel DCM lock supervisor: LOCKED synchroniser, lock debounce, unlock watchdog, DCM reset pulser
// and retry counter. Define DCM_SUP_FAULT_LATCH_EN to give up (fault) after MAX_RETRIES reset pulses.
module dcm_lock_supervisor #(
  parameter  int NUM_CHANNELS       = 3,
  parameter  int TIMEOUT_CYCLES     = 50000,
  parameter  int RESET_PULSE_CYCLES = 10,
  parameter  int STABLE_CYCLES      = 16,
  parameter  int MAX_RETRIES        = 7,
  parameter  int TIMER_WIDTH        = 16,
  localparam int RETRY_W            = $clog2(MAX_RETRIES + 1)
) (
  input  logic                              input_clk,
  input  logic                              reset_n,
  input  logic [NUM_CHANNELS-1:0]           dcm_locked,
  input  logic                              fault_clear,
  output logic [NUM_CHANNELS-1:0]           dcm_reset,
  output logic [NUM_CHANNELS-1:0]           clock_ready,
  output logic                              all_ready,
  output logic [NUM_CHANNELS-1:0]           fault,
  output logic [NUM_CHANNELS*RETRY_W-1:0]   retry_count
);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_STABLE,
    ST_READY,
    ST_RESET,
    ST_FAULT
  } state_e;

  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] PULSE_LAST   = TIMER_WIDTH'(RESET_PULSE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] STABLE_LAST  = TIMER_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0]     RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  logic [NUM_CHANNELS-1:0] sync1_q;
  logic [NUM_CHANNELS-1:0] lk_q;
  logic [NUM_CHANNELS-1:0] ready_d;
  logic                    all_ready_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      lk_q        <= '0;
      all_ready_q <= 1'b0;
    end else begin
      sync1_q     <= dcm_locked;
      lk_q        <= sync1_q;
      all_ready_q <= &ready_d;
    end
  end

  assign all_ready = all_ready_q;

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    state_e                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [RETRY_W-1:0]     retry_inc;
    logic                   dcm_reset_q;
    logic                   ready_q;

    assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      retry_d = retry_q;
      unique case (state_q)
        ST_WAIT: begin
          if (lk_q[ch]) begin
            state_d = ST_STABLE;
            timer_d = '0;
          end else if (timer_q == TIMEOUT_LAST) begin
            state_d = ST_RESET;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_STABLE: begin
          // Lock loss takes priority over reaching the stable terminal count.
          if (!lk_q[ch]) begin
            state_d = ST_WAIT;
            timer_d = '0;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_READY;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_READY: begin
          timer_d = '0;
          if (!lk_q[ch]) state_d = ST_WAIT;
        end
        ST_RESET: begin
          if (timer_q == PULSE_LAST) begin
            timer_d = '0;
            retry_d = retry_inc;
`ifdef DCM_SUP_FAULT_LATCH_EN
            state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_WAIT;
`else
            state_d = ST_WAIT;
`endif
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
`ifdef DCM_SUP_FAULT_LATCH_EN
        ST_FAULT: begin
          timer_d = '0;
          if (fault_clear) begin
            state_d = ST_WAIT;
            retry_d = '0;
          end
        end
`endif
        default: begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
      endcase
    end

    assign ready_d[ch] = (state_d == ST_READY);

    always_ff @(posedge input_clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q     <= ST_WAIT;
        timer_q     <= '0;
        retry_q     <= '0;
        dcm_reset_q <= 1'b0;
        ready_q     <= 1'b0;
      end else begin
        state_q     <= state_d;
        timer_q     <= timer_d;
        retry_q     <= retry_d;
        dcm_reset_q <= (state_d == ST_RESET) || (state_d == ST_FAULT);
        ready_q     <= ready_d[ch];
      end
    end

    assign dcm_reset[ch]                       = dcm_reset_q;
    assign clock_ready[ch]                     = ready_q;
    assign retry_count[ch*RETRY_W +: RETRY_W]  = retry_q;

`ifdef DCM_SUP_FAULT_LATCH_EN
    logic fault_q;

    always_ff @(posedge input_clk or negedge reset_n) begin
      if (!reset_n) fault_q <= 1'b0;
      else          fault_q <= (state_d == ST_FAULT);
    end

    assign fault[ch] = fault_q;
`endif
  end

`ifndef DCM_SUP_FAULT_LATCH_EN
  // Without the fault latch the supervisor retries forever and fault_clear has nothing to act on.
  logic unused_fault_clear;
  assign unused_fault_clear = fault_clear;
  assign fault              = '0;
`endif

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Directed bench for dcm_lock_supervisor (N=2, TIMEOUT=20, PULSE=4, STABLE=8, MAX_RETRIES=3).
// Cycle c means the state just after the c-th rising edge following reset release.
module tb_dcm_lock_supervisor;

  localparam int N       = 2;
  localparam int RETRY_W = 2;

  logic              input_clk;
  logic              reset_n;
  logic [N-1:0]      dcm_locked;
  logic              fault_clear;
  logic [N-1:0]      dcm_reset;
  logic [N-1:0]      clock_ready;
  logic              all_ready;
  logic [N-1:0]      fault;
  logic [N*RETRY_W-1:0] retry_count;

  int checks;
  int errors;
  int cyc;
  logic saw_rst0;
  logic track_rst0;

  dcm_lock_supervisor #(
    .NUM_CHANNELS      (N),
    .TIMEOUT_CYCLES    (20),
    .RESET_PULSE_CYCLES(4),
    .STABLE_CYCLES     (8),
    .MAX_RETRIES       (3),
    .TIMER_WIDTH       (16)
  ) dut (
    .input_clk  (input_clk),
    .reset_n    (reset_n),
    .dcm_locked (dcm_locked),
    .fault_clear(fault_clear),
    .dcm_reset  (dcm_reset),
    .clock_ready(clock_ready),
    .all_ready  (all_ready),
    .fault      (fault),
    .retry_count(retry_count)
  );

  initial input_clk = 1'b0;
  always #5 input_clk = ~input_clk;

  always @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) cyc = 0;
    else          cyc = cyc + 1;
  end

  always @(negedge input_clk) begin
    if (track_rst0 && dcm_reset[0]) saw_rst0 = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after edge c; a stalled counter is reported and the run stops.
  task automatic at_cycle(input int c);
    int guard = 0;
    while (cyc < c) begin
      @(posedge input_clk);
      #1;
      guard++;
      if (guard > 2000) begin
        $display("FAIL at_cycle_timeout: observed cycle %0d expected %0d", cyc, c);
        $fatal(1, "cycle counter stalled");
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    saw_rst0    = 1'b0;
    track_rst0  = 1'b0;
    reset_n     = 1'b0;
    fault_clear = 1'b0;
    dcm_locked  = 2'b01;
    #23;
    check("reset_dcm_reset", 32'(dcm_reset), 32'h0);
    check("reset_clock_ready", 32'(clock_ready), 32'h0);
    check("reset_all_ready", 32'(all_ready), 32'h0);
    check("reset_fault", 32'(fault), 32'h0);
    check("reset_retry", 32'(retry_count), 32'h0);

    reset_n    = 1'b1;
    track_rst0 = 1'b1;

    // ch0 locked from release: sync (2) + WAIT->STABLE (1) + 8 stable cycles.
    at_cycle(10);
    check("ch0_ready_early", 32'(clock_ready), 32'h0);
    at_cycle(11);
    check("ch0_ready", 32'(clock_ready), 32'h1);
    check("all_ready_ch1_unlocked", 32'(all_ready), 32'h0);

    // ch1 never locks: first pulse after 20 WAIT cycles, 4 cycles wide.
    at_cycle(19);
    check("ch1_pulse1_before", 32'(dcm_reset), 32'h0);
    at_cycle(20);
    check("ch1_pulse1_start", 32'(dcm_reset), 32'h2);
    at_cycle(23);
    check("ch1_pulse1_end", 32'(dcm_reset), 32'h2);
    check("ch1_retry_during", 32'(retry_count[3:2]), 32'h0);
    at_cycle(24);
    check("ch1_pulse1_off", 32'(dcm_reset), 32'h0);
    check("ch1_retry1", 32'(retry_count[3:2]), 32'h1);

    // ch0 loses lock while READY.
    at_cycle(30);
    dcm_locked[0] = 1'b0;
    at_cycle(32);
    check("ch0_loss_still_ready", 32'(clock_ready), 32'h1);
    at_cycle(33);
    check("ch0_loss_fall", 32'(clock_ready), 32'h0);
    check("ch0_retry_unchanged", 32'(retry_count[1:0]), 32'h0);

    // ch0 relocks, then a one-cycle glitch at stable count 5 restarts the debounce.
    at_cycle(35);
    dcm_locked[0] = 1'b1;
    at_cycle(41);
    dcm_locked[0] = 1'b0;
    at_cycle(42);
    dcm_locked[0] = 1'b1;
    at_cycle(44);
    check("ch1_pulse2_start", 32'(dcm_reset), 32'h2);
    at_cycle(48);
    check("ch0_glitch_no_ready", 32'(clock_ready), 32'h0);
    check("ch1_retry2", 32'(retry_count[3:2]), 32'h2);
    at_cycle(52);
    check("ch0_relock_early", 32'(clock_ready), 32'h0);
    at_cycle(53);
    check("ch0_relock_ready", 32'(clock_ready), 32'h1);

    at_cycle(68);
    check("ch1_pulse3_start", 32'(dcm_reset), 32'h2);
    at_cycle(72);
    check("ch1_retry3", 32'(retry_count[3:2]), 32'h3);
`ifdef DCM_SUP_FAULT_LATCH_EN
    check("ch1_fault_set", 32'(fault), 32'h2);
    check("ch1_fault_holds_reset", 32'(dcm_reset), 32'h2);
    at_cycle(80);
    check("ch1_fault_held", 32'(dcm_reset), 32'h2);
    fault_clear = 1'b1;
    at_cycle(81);
    fault_clear = 1'b0;
    check("fault_clear_fault", 32'(fault), 32'h0);
    check("fault_clear_reset", 32'(dcm_reset), 32'h0);
    check("fault_clear_retry", 32'(retry_count[3:2]), 32'h0);
    at_cycle(100);
    check("repulse_before", 32'(dcm_reset), 32'h0);
    at_cycle(101);
    check("repulse_start", 32'(dcm_reset), 32'h2);
    at_cycle(102);
`else
    check("ch1_no_fault", 32'(fault), 32'h0);
    check("ch1_pulse3_off", 32'(dcm_reset), 32'h0);
    at_cycle(80);
    fault_clear = 1'b1;
    at_cycle(81);
    fault_clear = 1'b0;
    check("fault_clear_ignored", 32'(retry_count[3:2]), 32'h3);
    at_cycle(92);
    check("ch1_pulse4_start", 32'(dcm_reset), 32'h2);
    at_cycle(96);
    check("ch1_retry_saturated", 32'(retry_count[3:2]), 32'h3);
    at_cycle(117);
`endif
    check("ch0_no_reset_pulses", 32'(saw_rst0), 32'h0);
    track_rst0 = 1'b0;

    // Mid-pulse asynchronous reset: dcm_reset must drop without waiting for an edge.
    check("midpulse_high", 32'(dcm_reset), 32'h2);
    #3;
    reset_n    = 1'b0;
    dcm_locked = 2'b11;
    #1;
    check("async_reset_dcm_reset", 32'(dcm_reset), 32'h0);
    check("async_reset_retry", 32'(retry_count), 32'h0);
    check("async_reset_ready", 32'(clock_ready), 32'h0);
    #20;
    reset_n = 1'b1;

    at_cycle(10);
    check("restart_all_ready_early", 32'(all_ready), 32'h0);
    at_cycle(11);
    check("restart_clock_ready", 32'(clock_ready), 32'h3);
    check("restart_all_ready", 32'(all_ready), 32'h1);
    at_cycle(15);
    dcm_locked[0] = 1'b0;
    at_cycle(17);
    check("all_ready_before_fall", 32'(all_ready), 32'h1);
    at_cycle(18);
    check("all_ready_fall", 32'(all_ready), 32'h0);
    check("clock_ready_fall", 32'(clock_ready), 32'h2);
    check("retry_after_fall", 32'(retry_count), 32'h0);
    at_cycle(25);
    check("restart_no_pulse", 32'(dcm_reset), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
